// File: rtl/fc2_mac_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : fc2_mac_engine_if
//  Description : Bundle of control, memory-read and score-output signals
//                connecting the FC2 MAC engine to its surroundings.
//                master = engine side, slave = environment/memories.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fc2_mac_engine_if #(
    parameter int DATA_W = 8
);
    // control
    logic                start;
    logic                busy;
    logic                done;
    // activation buffer read port (1-cycle latency)
    logic [6:0]          act_addr;
    logic [DATA_W-1:0]   act_data;
    // weight ROM read port (1-cycle latency)
    logic [9:0]          w_addr;
    logic [DATA_W-1:0]   w_data;
    // bias ROM read port (1-cycle latency)
    logic [3:0]          bias_addr;
    logic [31:0]         bias_data;
    // score stream
    logic [31:0]         result_data;
    logic [3:0]          result_idx;
    logic                result_valid;

    modport master (
        input  start, act_data, w_data, bias_data,
        output busy, done, act_addr, w_addr, bias_addr,
               result_data, result_idx, result_valid
    );

    modport slave (
        output start, act_data, w_data, bias_data,
        input  busy, done, act_addr, w_addr, bias_addr,
               result_data, result_idx, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/fc2_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fc2_mac_engine
//  Description : Sequential fully-connected layer (FC2). For every output
//                neuron it loads the bias, accumulates IN_LEN signed
//                activation*weight products and emits one registered score.
//                Per-neuron period is IN_LEN+2 cycles (BIAS, MAC x IN_LEN,
//                EMIT), followed by a single DONE cycle per pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc2_mac_engine #(
    parameter int IN_LEN  = 84,
    parameter int OUT_LEN = 10,
    parameter int DATA_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fc2_mac_engine_if.master   bus
);

    localparam int         PROD_W = 2 * DATA_W;
    localparam logic [6:0] K_LAST = 7'(IN_LEN - 1);
    localparam logic [3:0] N_LAST = 4'(OUT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_MAC  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    state_q;
    logic [6:0]                k_q;
    logic [3:0]                neuron_q;
    logic signed [31:0]        acc_q;

    logic [6:0]                act_addr_q;
    logic [9:0]                w_addr_q;
    logic [3:0]                bias_addr_q;

    logic                      busy_q;
    logic                      done_q;
    logic                      result_valid_q;
    logic [31:0]               result_data_q;
    logic [3:0]                result_idx_q;

    logic signed [PROD_W-1:0]  prod_d;
    logic signed [31:0]        prod_ext_d;
    logic signed [31:0]        acc_d;
    logic                      addr_adv_d;

    // Product, sign extension and next accumulator value for the current MAC step.
    // The bias replaces the running sum on the first element of each neuron.
    always_comb begin
        prod_d     = $signed(bus.act_data) * $signed(bus.w_data);
        prod_ext_d = {{(32 - PROD_W){prod_d[PROD_W-1]}}, prod_d};
        acc_d      = ((k_q == 7'd0) ? $signed(bus.bias_data) : acc_q) + prod_ext_d;
        addr_adv_d = (act_addr_q < K_LAST);
    end

    // Main controller: sequencing, address generation, accumulation and
    // registered outputs. Addresses run one element ahead of the MAC step to
    // cover the single-cycle read latency of the memories.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            k_q            <= 7'd0;
            neuron_q       <= 4'd0;
            acc_q          <= 32'sd0;
            act_addr_q     <= 7'd0;
            w_addr_q       <= 10'd0;
            bias_addr_q    <= 4'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= 32'd0;
            result_idx_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q     <= S_BIAS;
                        busy_q      <= 1'b1;
                        neuron_q    <= 4'd0;
                        k_q         <= 7'd0;
                        bias_addr_q <= 4'd0;
                        act_addr_q  <= 7'd0;
                        w_addr_q    <= 10'd0;
                    end
                end

                S_BIAS: begin
                    state_q <= S_MAC;
                    k_q     <= 7'd0;
                    if (addr_adv_d) begin
                        act_addr_q <= act_addr_q + 7'd1;
                        w_addr_q   <= w_addr_q + 10'd1;
                    end
                end

                S_MAC: begin
                    acc_q <= acc_d;
                    if (addr_adv_d) begin
                        act_addr_q <= act_addr_q + 7'd1;
                        w_addr_q   <= w_addr_q + 10'd1;
                    end
                    if (k_q == K_LAST) begin
                        state_q        <= S_EMIT;
                        result_valid_q <= 1'b1;
                        result_data_q  <= acc_d;
                        result_idx_q   <= neuron_q;
                    end else begin
                        k_q <= k_q + 7'd1;
                    end
                end

                S_EMIT: begin
                    result_valid_q <= 1'b0;
                    if (neuron_q < N_LAST) begin
                        // The weight pointer sits on the last element of this
                        // row, so +1 is the first element of the next row.
                        state_q     <= S_BIAS;
                        neuron_q    <= neuron_q + 4'd1;
                        bias_addr_q <= neuron_q + 4'd1;
                        act_addr_q  <= 7'd0;
                        w_addr_q    <= w_addr_q + 10'd1;
                        k_q         <= 7'd0;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q        <= S_IDLE;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output drive from registers only.
    always_comb begin
        bus.busy         = busy_q;
        bus.done         = done_q;
        bus.act_addr     = act_addr_q;
        bus.w_addr       = w_addr_q;
        bus.bias_addr    = bias_addr_q;
        bus.result_valid = result_valid_q;
        bus.result_data  = result_data_q;
        bus.result_idx   = result_idx_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fc2_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc2_mac_engine
//  Description : Directed self-checking bench for fc2_mac_engine with
//                behavioural 1-cycle-latency activation/weight/bias memories.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc2_mac_engine;

    localparam int IN_LEN  = 84;
    localparam int OUT_LEN = 10;
    localparam int DATA_W  = 8;
    localparam int PERIOD  = IN_LEN + 2;

    logic clk;
    logic rst_n;

    fc2_mac_engine_if #(.DATA_W(DATA_W)) bus ();

    fc2_mac_engine #(
        .IN_LEN (IN_LEN),
        .OUT_LEN(OUT_LEN),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic signed [DATA_W-1:0] act_mem  [0:127];
    logic signed [DATA_W-1:0] w_mem    [0:1023];
    logic signed [31:0]       bias_mem [0:15];
    int                       exp_score[0:OUT_LEN-1];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int last_argmax;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Synchronous-read memory models
    always @(posedge clk) begin
        bus.act_data  <= act_mem[bus.act_addr];
        bus.w_data    <= w_mem[bus.w_addr];
        bus.bias_data <= bias_mem[bus.bias_addr];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input int w, input int w7, input bit bias_ramp);
        for (int i = 0; i < 128; i++) act_mem[i] = 8'(a);
        for (int i = 0; i < 1024; i++) w_mem[i] = ((i / IN_LEN) == 7) ? 8'(w7) : 8'(w);
        for (int i = 0; i < 16; i++) bias_mem[i] = bias_ramp ? 32'(-5 + i) : 32'sd0;
    endtask

    // One pass from start; edge 0 is the edge that samples start, cycle c is
    // the period ending at edge c.
    task automatic run_pass(input string tag, input bit pulse_at_300, input bit reset_at_300);
        int c, t0, npulse, busy_err, order_err, hold_err, done_cnt, done_cyc;
        int p_cyc[OUT_LEN];
        int p_idx[OUT_LEN];
        int p_dat[OUT_LEN];
        logic prev_v;
        logic [31:0] held_d;
        logic [3:0]  held_i;
        npulse = 0; busy_err = 0; order_err = 0; hold_err = 0;
        done_cnt = 0; done_cyc = -1; prev_v = 1'b0;
        for (int i = 0; i < OUT_LEN; i++) begin p_cyc[i] = -1; p_idx[i] = -1; p_dat[i] = 0; end
        @(negedge clk);
        held_d = bus.result_data;
        held_i = bus.result_idx;
        bus.start = 1'b1;
        t0 = edge_cnt;
        c = 0;
        while (c < 880) begin
            @(negedge clk);
            c = edge_cnt - t0;
            if (c == 1) bus.start = 1'b0;
            if (pulse_at_300 && c == 300) bus.start = 1'b1;
            if (pulse_at_300 && c == 301) bus.start = 1'b0;
            if (reset_at_300 && c == 300) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"},  longint'(bus.busy), 0);
                check({tag, "_rst_valid"}, longint'(bus.result_valid), 0);
                check({tag, "_rst_waddr"}, longint'(bus.w_addr), 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (bus.busy !== ((c >= 1 && c <= 861) ? 1'b1 : 1'b0)) busy_err++;
            if (bus.result_valid === 1'b1) begin
                if (prev_v) order_err++;
                if (npulse < OUT_LEN) begin
                    p_cyc[npulse] = c;
                    p_idx[npulse] = int'(bus.result_idx);
                    p_dat[npulse] = int'($signed(bus.result_data));
                end
                npulse++;
                held_d = bus.result_data;
                held_i = bus.result_idx;
            end else if (bus.result_data !== held_d || bus.result_idx !== held_i) begin
                hold_err++;
            end
            prev_v = (bus.result_valid === 1'b1);
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        check({tag, "_npulse"}, npulse, OUT_LEN);
        last_argmax = 0;
        for (int i = 0; i < OUT_LEN; i++) begin
            check($sformatf("%s_idx%0d", tag, i),  p_idx[i], i);
            check($sformatf("%s_data%0d", tag, i), p_dat[i], exp_score[i]);
            check($sformatf("%s_cyc%0d", tag, i),  p_cyc[i], PERIOD + PERIOD * i);
            if (p_dat[i] > p_dat[last_argmax]) last_argmax = i;
        end
        check({tag, "_done_cnt"},  done_cnt, 1);
        check({tag, "_done_cyc"},  done_cyc, 861);
        check({tag, "_busy_prof"}, busy_err, 0);
        check({tag, "_b2b_pulse"}, order_err, 0);
        check({tag, "_hold"},      hold_err, 0);
    endtask

    initial begin
        int stray;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        load(1, 1, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy",      longint'(bus.busy), 0);
        check("rst_done",      longint'(bus.done), 0);
        check("rst_valid",     longint'(bus.result_valid), 0);
        check("rst_data",      longint'(bus.result_data), 0);
        check("rst_idx",       longint'(bus.result_idx), 0);
        check("rst_act_addr",  longint'(bus.act_addr), 0);
        check("rst_w_addr",    longint'(bus.w_addr), 0);
        check("rst_bias_addr", longint'(bus.bias_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all ones, zero bias: 84 per neuron
        load(1, 1, 1, 1'b0);
        for (int i = 0; i < OUT_LEN; i++) exp_score[i] = 84;
        run_pass("ones", 1'b0, 1'b0);

        // zero activations: score is the bias alone
        load(0, 3, 3, 1'b1);
        for (int i = 0; i < OUT_LEN; i++) exp_score[i] = -5 + i;
        run_pass("bias", 1'b0, 1'b0);

        // most negative operands: 16384*84
        load(-128, -128, -128, 1'b0);
        for (int i = 0; i < OUT_LEN; i++) exp_score[i] = 1376256;
        run_pass("neg", 1'b0, 1'b0);

        // row 7 doubled: winner is neuron 7
        load(1, 1, 2, 1'b0);
        for (int i = 0; i < OUT_LEN; i++) exp_score[i] = (i == 7) ? 168 : 84;
        run_pass("row7", 1'b0, 1'b0);
        check("row7_argmax", last_argmax, 7);

        // second start mid-pass must be ignored
        load(1, 1, 1, 1'b0);
        for (int i = 0; i < OUT_LEN; i++) exp_score[i] = 84;
        run_pass("restart", 1'b1, 1'b0);

        // reset mid-pass, then silence, then a clean full pass
        run_pass("abort", 1'b0, 1'b1);
        stray = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        check("abort_quiet", stray, 0);
        run_pass("recover", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc2_mac_engine.md
FC2_MAC_ENGINE -- requirements
Module: fc2_mac_engine

Interface
REQ-001 SHALL have parameter IN_LEN, default 84, meaning FC2 input vector length.
REQ-002 SHALL have parameter OUT_LEN, default 10, meaning FC2 output neurons (class scores).
REQ-003 SHALL have parameter DATA_W, default 8, meaning signed activation/weight width.
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  in  1  request one full FC2 pass; sampled only in IDLE.
REQ-007 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse after the last score is emitted.
REQ-009 SHALL have port act_addr  out  7  activation buffer read address; data returns 1 cycle later.
REQ-010 SHALL have port act_data  in  DATA_W  signed activation read data.
REQ-011 SHALL have port w_addr  out  10  weight ROM address = neuron*IN_LEN + k; 1-cycle read latency.
REQ-012 SHALL have port w_data  in  DATA_W  signed weight read data.
REQ-013 SHALL have port bias_addr  out  4  bias ROM address = neuron; 1-cycle read latency.
REQ-014 SHALL have port bias_data  in  32  signed bias read data.
REQ-015 SHALL have port result_data  out  32  signed score of neuron result_idx.
REQ-016 SHALL have port result_idx  out  4  neuron index of result_data.
REQ-017 SHALL have port result_valid  out  1  one-cycle pulse per score; drives argmax enable downstream.

Function
REQ-018 SHALL implement FSM states IDLE, BIAS, MAC, EMIT, DONE.
REQ-019 SHALL go IDLE->BIAS on start=1, clearing neuron counter and weight pointer to 0; start ignored outside IDLE.
REQ-020 SHALL, in BIAS, drive bias_addr=neuron, act_addr=0, w_addr=neuron*IN_LEN, k=0, then go to MAC.
REQ-021 SHALL, in each MAC cycle k, set acc = (k==0 ? bias_data : acc) + act_data*w_data, and issue addresses for element k+1 when k<IN_LEN-1.
REQ-022 SHALL form the product as signed 2*DATA_W bits, sign-extend to 32, and accumulate with two's-complement wrap (no saturation).
REQ-023 SHALL, after MAC cycle k=IN_LEN-1, go to EMIT with result_valid=1, result_data=final acc, result_idx=neuron, all registered.
REQ-024 SHALL go EMIT->BIAS with neuron+1 if neuron<OUT_LEN-1, else EMIT->DONE.
REQ-025 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-026 SHALL have per-neuron period IN_LEN+2 cycles (86 default); with start sampled at edge 0, result_valid for neuron n high in cycle 86+86n, done high in cycle 861, busy high cycles 1..861.
REQ-027 SHALL emit exactly OUT_LEN result_valid pulses per pass, in ascending result_idx order, never two on consecutive cycles.
REQ-028 SHALL hold result_data/result_idx stable between pulses; result_valid low in all non-EMIT cycles.
REQ-029 SHALL accept start asserted in the DONE cycle only on the following IDLE cycle (no back-to-back merge).
REQ-030 SHALL hold address outputs at last issued value outside BIAS/MAC.

Reset
REQ-031 SHALL, on rst_n low at any time, go to IDLE asynchronously with busy, done, result_valid, result_data, result_idx, act_addr, w_addr, bias_addr, acc and counters all 0.
REQ-032 SHALL, after reset mid-pass, produce no further result_valid until a new start, and the new pass SHALL be complete and correct.

Verification
REQ-033 SHALL test all act=1, w=1, bias=0 -> ten pulses, result_data=84 each, idx 0..9, pulses at cycles 86,172,...,860, done at 861.
REQ-034 SHALL test act=0, bias[n]=-5+n -> result_data=-5..4 in order.
REQ-035 SHALL test act=-128, w=-128, bias=0 -> result_data=1376256 each (no overflow, sign correct).
REQ-036 SHALL test weight row 7 all 2, others 1, act=1 -> score 7 = 168, downstream argmax reports 7.
REQ-037 SHALL test start pulsed again at cycle 300 -> ignored, still exactly 10 pulses, done at 861.
REQ-038 SHALL test rst_n low at cycle 300 -> busy/result_valid 0 immediately; new start gives ten correct scores with original timing.
